request_queue: RTL and testbench

- In-order request queue directly downstream of the trace parser.
- Captures each parsed memory request (opcode, address) when it is strobed, and holds up to QUEUE_DEPTH pending requests.
- Presents the oldest request to the DRAM command scheduler, which pops it with a ready/valid handshake.
- Tracks per-entry age in clock cycles so the scheduler can enforce timing and starvation rules.

---
 rtl/request_queue_if.sv | 42 ++++
 rtl/request_queue.sv | 145 ++++++++++++++
 tb/tb_request_queue.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/request_queue_if.sv
// Request queue opcode package and handshake interface.
// The parser/scheduler side uses the master modport; the queue uses slave.

package request_queue_pkg;
    typedef enum logic [1:0] {
        READ   = 2'd0,
        WRITE  = 2'd1,
        IFETCH = 2'd2,
        NOP    = 2'd3
    } parsed_op_t;
endpackage

interface request_queue_if #(
    parameter int QUEUE_DEPTH   = 16,
    parameter int ADDRESS_WIDTH = 33,
    parameter int AGE_WIDTH     = 16
);
    localparam int COUNT_WIDTH = $clog2(QUEUE_DEPTH) + 1;

    logic                             in_valid;
    request_queue_pkg::parsed_op_t    in_op;
    logic [ADDRESS_WIDTH-1:0]         in_addr;
    logic                             in_ready;
    logic                             out_valid;
    request_queue_pkg::parsed_op_t    out_op;
    logic [ADDRESS_WIDTH-1:0]         out_addr;
    logic [AGE_WIDTH-1:0]             out_age;
    logic                             out_ready;
    logic [COUNT_WIDTH-1:0]           count;
    logic                             full;
    logic                             empty;

    modport master (
        output in_valid, in_op, in_addr, out_ready,
        input  in_ready, out_valid, out_op, out_addr, out_age, count, full, empty
    );

    modport slave (
        input  in_valid, in_op, in_addr, out_ready,
        output in_ready, out_valid, out_op, out_addr, out_age, count, full, empty
    );
endinterface

// File: rtl/request_queue.sv
// In-order request queue between the trace parser and the DRAM scheduler.
// Circular buffer with per-entry saturating age counters; the head entry is
// presented combinationally. Optional statistics/logging: REQUEST_QUEUE_STATS_EN.

module request_queue
    import request_queue_pkg::*;
#(
    parameter int QUEUE_DEPTH   = 16,
    parameter int ADDRESS_WIDTH = 33,
    parameter int AGE_WIDTH     = 16
) (
    input logic clk,
    input logic rst,
    request_queue_if.slave bus
`ifdef REQUEST_QUEUE_STATS_EN
    ,
    output logic [31:0]                     stat_pushes,
    output logic [31:0]                     stat_pops,
    output logic [$clog2(QUEUE_DEPTH):0]    stat_peak
`endif
);

    localparam int PTR_WIDTH   = $clog2(QUEUE_DEPTH);
    localparam int COUNT_WIDTH = PTR_WIDTH + 1;
    localparam logic [COUNT_WIDTH-1:0] DEPTH_COUNT = COUNT_WIDTH'(QUEUE_DEPTH);
    localparam logic [AGE_WIDTH-1:0]   AGE_MAX     = '1;

    logic [PTR_WIDTH-1:0]     head;
    logic [PTR_WIDTH-1:0]     tail;
    logic [COUNT_WIDTH-1:0]   count_q;
    logic [COUNT_WIDTH-1:0]   count_next;

    parsed_op_t               op_mem   [QUEUE_DEPTH];
    logic [ADDRESS_WIDTH-1:0] addr_mem [QUEUE_DEPTH];
    logic [AGE_WIDTH-1:0]     age_mem  [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0]   valid_mem;

    logic full_int;
    logic empty_int;
    logic head_valid;
    logic push;
    logic pop;

    assign full_int   = (count_q == DEPTH_COUNT);
    assign empty_int  = (count_q == '0);
    assign head_valid = valid_mem[head];

    // NOP strobes are not requests; a full queue refuses even if it pops this cycle.
    assign push = bus.in_valid && !full_int && (bus.in_op != NOP);
    assign pop  = head_valid && bus.out_ready;

    // Occupancy follows push/pop; a simultaneous pair leaves it unchanged.
    always_comb begin
        count_next = count_q;
        case ({push, pop})
            2'b10:   count_next = count_q + COUNT_WIDTH'(1);
            2'b01:   count_next = count_q - COUNT_WIDTH'(1);
            default: count_next = count_q;
        endcase
    end

    // Head/tail pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push) tail <= tail + PTR_WIDTH'(1);
            if (pop)  head <= head + PTR_WIDTH'(1);
            count_q <= count_next;
        end
    end

    // Entry storage: write on push, retire on pop, otherwise age every valid entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_mem <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                op_mem[i]   <= NOP;
                addr_mem[i] <= '0;
                age_mem[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (push && (tail == PTR_WIDTH'(i))) begin
                    valid_mem[i] <= 1'b1;
                    op_mem[i]    <= bus.in_op;
                    addr_mem[i]  <= bus.in_addr;
                    age_mem[i]   <= '0;
                end else if (pop && (head == PTR_WIDTH'(i))) begin
                    valid_mem[i] <= 1'b0;
                    age_mem[i]   <= '0;
                end else if (valid_mem[i] && (age_mem[i] != AGE_MAX)) begin
                    age_mem[i] <= age_mem[i] + AGE_WIDTH'(1);
                end
            end
        end
    end

    // Head entry drives the scheduler side; an empty head reads as a NOP at address 0.
    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_op    = NOP;
        bus.out_addr  = '0;
        bus.out_age   = '0;
        if (head_valid) begin
            bus.out_valid = 1'b1;
            bus.out_op    = op_mem[head];
            bus.out_addr  = addr_mem[head];
            bus.out_age   = age_mem[head];
        end
    end

    assign bus.in_ready = !full_int;
    assign bus.count    = count_q;
    assign bus.full     = full_int;
    assign bus.empty    = empty_int;

`ifdef REQUEST_QUEUE_STATS_EN
    logic [31:0] cycle_count;

    // Running push/pop totals, peak occupancy and a transaction log.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count <= '0;
            stat_pushes <= '0;
            stat_pops   <= '0;
            stat_peak   <= '0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (push) begin
                stat_pushes <= stat_pushes + 32'd1;
                $display("[RQ] cycle %0d PUSH op=%s addr=%h", cycle_count, bus.in_op.name(), bus.in_addr);
            end
            if (pop) begin
                stat_pops <= stat_pops + 32'd1;
                $display("[RQ] cycle %0d POP op=%s addr=%h", cycle_count, op_mem[head].name(), addr_mem[head]);
            end
            if (count_next > stat_peak) stat_peak <= count_next;
        end
    end
`endif

endmodule

// File: tb/tb_request_queue.sv
// Self-checking bench for request_queue: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// queue-based reference model.

module tb_request_queue;
    import request_queue_pkg::*;

    localparam int QUEUE_DEPTH   = 16;
    localparam int ADDRESS_WIDTH = 33;
    localparam int AGE_WIDTH     = 16;
    localparam int AGE_MAX       = (1 << AGE_WIDTH) - 1;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    request_queue_if #(
        .QUEUE_DEPTH(QUEUE_DEPTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .AGE_WIDTH(AGE_WIDTH)
    ) bus ();

`ifdef REQUEST_QUEUE_STATS_EN
    logic [31:0]                  stat_pushes;
    logic [31:0]                  stat_pops;
    logic [$clog2(QUEUE_DEPTH):0] stat_peak;
`endif

    request_queue #(
        .QUEUE_DEPTH(QUEUE_DEPTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .AGE_WIDTH(AGE_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef REQUEST_QUEUE_STATS_EN
        ,
        .stat_pushes(stat_pushes),
        .stat_pops(stat_pops),
        .stat_peak(stat_peak)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain FIFO of {op, addr, age}.
    typedef struct {
        parsed_op_t               op;
        logic [ADDRESS_WIDTH-1:0] addr;
        int                       age;
    } entry_t;

    entry_t model_q[$];

    // The model applies the queue's rules on each clock edge; reset empties it at once.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q.delete();
        end else begin
            bit do_push;
            bit do_pop;
            entry_t e;
            do_push = bus.in_valid && (model_q.size() < QUEUE_DEPTH) && (bus.in_op != NOP);
            do_pop  = bus.out_ready && (model_q.size() > 0);
            foreach (model_q[i]) begin
                if (model_q[i].age < AGE_MAX) model_q[i].age++;
            end
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                e.op   = bus.in_op;
                e.addr = bus.in_addr;
                e.age  = 0;
                model_q.push_back(e);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Every cycle out of reset, the DUT outputs must match what the model holds.
    always @(negedge clk) begin
        if (!rst) begin
            int n;
            n = model_q.size();
            checkOutput("cyc_count",    64'(bus.count),     64'(n));
            checkOutput("cyc_full",     64'(bus.full),      64'(n == QUEUE_DEPTH));
            checkOutput("cyc_empty",    64'(bus.empty),     64'(n == 0));
            checkOutput("cyc_in_ready", 64'(bus.in_ready),  64'(n != QUEUE_DEPTH));
            checkOutput("cyc_out_valid",64'(bus.out_valid), 64'(n != 0));
            if (n != 0) begin
                checkOutput("cyc_out_op",   64'(bus.out_op),   64'(model_q[0].op));
                checkOutput("cyc_out_addr", 64'(bus.out_addr), 64'(model_q[0].addr));
                checkOutput("cyc_out_age",  64'(bus.out_age),  64'(model_q[0].age));
            end else begin
                checkOutput("cyc_out_op",   64'(bus.out_op),   64'(NOP));
                checkOutput("cyc_out_addr", 64'(bus.out_addr), 64'd0);
                checkOutput("cyc_out_age",  64'(bus.out_age),  64'd0);
            end
        end
    end

    // Drive one cycle of inputs from a negedge and return at the following negedge.
    task automatic applyStimulus(input logic valid, input parsed_op_t op,
                                 input logic [ADDRESS_WIDTH-1:0] addr, input logic ready);
        bus.in_valid  = valid;
        bus.in_op     = op;
        bus.in_addr   = addr;
        bus.out_ready = ready;
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, NOP, '0, 1'b0);
    endtask

    // Hard bound on total run time.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [ADDRESS_WIDTH-1:0] a;
        parsed_op_t op;
        bus.in_valid  = 1'b0;
        bus.in_op     = NOP;
        bus.in_addr   = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset then idle.
        idle(5);
        checkOutput("reset_empty",     64'(bus.empty),     64'd1);
        checkOutput("reset_in_ready",  64'(bus.in_ready),  64'd1);
        checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset_out_op",    64'(bus.out_op),    64'(NOP));
        checkOutput("reset_count",     64'(bus.count),     64'd0);

        // Single push becomes visible one cycle later with age 0, then ages.
        applyStimulus(1'b1, READ, 33'h1_0000_0040, 1'b0);
        checkOutput("push_visible", 64'(bus.out_valid), 64'd1);
        checkOutput("push_addr",    64'(bus.out_addr),  64'h1_0000_0040);
        checkOutput("push_age0",    64'(bus.out_age),   64'd0);
        idle(4);
        checkOutput("push_age4",    64'(bus.out_age),   64'd4);
        applyStimulus(1'b0, NOP, '0, 1'b1);
        checkOutput("pop_single_empty", 64'(bus.empty), 64'd1);

        // Fill to depth (tail wraps since head sits at 1), drop the 17th, drain in order.
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            a  = 33'h0_0000_1000 + 33'(i * 'h40);
            op = parsed_op_t'(i % 3);
            applyStimulus(1'b1, op, a, 1'b0);
        end
        checkOutput("fill_full",     64'(bus.full),     64'd1);
        checkOutput("fill_in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("fill_count",    64'(bus.count),    64'd16);
        applyStimulus(1'b1, WRITE, 33'h1_FFFF_FFFF, 1'b0);
        checkOutput("drop17_count",  64'(bus.count),    64'd16);
        checkOutput("drop17_head",   64'(bus.out_addr), 64'h1000);
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            checkOutput("drain_order", 64'(bus.out_addr), 64'(33'h0_0000_1000 + 33'(i * 'h40)));
            applyStimulus(1'b0, NOP, '0, 1'b1);
        end
        checkOutput("drain_empty", 64'(bus.empty), 64'd1);

        // Simultaneous push and pop at count 3.
        applyStimulus(1'b1, READ,   33'h100, 1'b0);
        applyStimulus(1'b1, WRITE,  33'h200, 1'b0);
        applyStimulus(1'b1, IFETCH, 33'h300, 1'b0);
        applyStimulus(1'b1, WRITE,  33'h400, 1'b1);
        checkOutput("pushpop_count", 64'(bus.count),    64'd3);
        checkOutput("pushpop_head",  64'(bus.out_addr), 64'h200);
        applyStimulus(1'b0, NOP, '0, 1'b1);
        applyStimulus(1'b0, NOP, '0, 1'b1);
        checkOutput("pushpop_third", 64'(bus.out_addr), 64'h400);
        checkOutput("pushpop_op",    64'(bus.out_op),   64'(WRITE));

        // NOP strobe is ignored.
        applyStimulus(1'b1, NOP, 33'hABC, 1'b0);
        checkOutput("nop_count", 64'(bus.count),     64'd1);
        checkOutput("nop_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("nop_head",  64'(bus.out_addr),  64'h400);

        // Fill to 5, then asynchronous reset between clock edges.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, READ, 33'(32'h500 + i), 1'b0);
        checkOutput("pre_reset_count", 64'(bus.count), 64'd5);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_count", 64'(bus.count),     64'd0);
        checkOutput("async_rst_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, WRITE, 33'h20, 1'b0);
        checkOutput("post_rst_addr", 64'(bus.out_addr), 64'h20);
        checkOutput("post_rst_op",   64'(bus.out_op),   64'(WRITE));
        checkOutput("post_rst_age",  64'(bus.out_age),  64'd0);

        // Randomized traffic alternating between fill-heavy and drain-heavy phases.
        for (int i = 0; i < 2000; i++) begin
            int push_pct;
            int pop_pct;
            logic v;
            logic r;
            push_pct = ((i / 250) % 2 == 0) ? 80 : 30;
            pop_pct  = ((i / 250) % 2 == 0) ? 30 : 80;
            v  = ($urandom_range(0, 99) < push_pct);
            r  = ($urandom_range(0, 99) < pop_pct);
            op = parsed_op_t'($urandom_range(0, 3));
            a  = {1'($urandom_range(0, 1)), 32'($urandom)};
            applyStimulus(v, op, a, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
